// File: rtl/spi_cfg_regs_pkg.sv
// Shared definitions for the SPI configuration register block.
// Contents: default frame length, register address map, FSM state type.
package spi_cfg_regs_pkg;

  localparam int unsigned FRAME_BITS_DEFAULT = 16;

  // Register address map (7-bit address field of the frame)
  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

endpackage

// File: rtl/spi_cfg_regs_sync_ff.sv
// Single-bit multi-flop synchronizer with synchronous reset to a chosen level.
// Ports:
//   clk  - destination clock
//   rst  - synchronous active-high reset, loads RST_VAL into every stage
//   d    - asynchronous input
//   q    - synchronized output (last stage)
module sync_ff #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_cfg_regs.sv
// SPI (mode 0) peripheral that accepts write frames into five 8-bit
// configuration registers. Frame, MSB first: R/W bit, 7-bit address, 8-bit data.
// Ports:
//   clk, rst                        - system clock, synchronous active-high reset
//   sclk, copi, ncs                 - SPI pins, asynchronous to clk
//   en_reg_out_7_0/15_8             - output-enable registers
//   en_reg_pwm_7_0/15_8             - PWM-mode enable registers
//   pwm_duty_cycle                  - PWM duty register
//   wr_strobe                       - one-cycle pulse for each committed write
//   frame_err                       - one-cycle pulse for each discarded frame
module spi_cfg_regs
  import spi_cfg_regs_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FRAME_BITS  = FRAME_BITS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic       frame_err
);

  localparam int unsigned CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);

  localparam int unsigned FL_W = $clog2(SYNC_STAGES + 2);
  localparam logic [FL_W-1:0] FL_MAX = FL_W'(SYNC_STAGES + 1);

  logic sclk_s, copi_s, ncs_s;
  logic sclk_q, ncs_q;
  logic [FL_W-1:0] flush_cnt;
  logic edges_ok;
  logic sclk_rise, ncs_fall, ncs_rise;

  state_t                state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  fall_pend;

  logic       frame_rw;
  logic [6:0] frame_addr;
  logic [7:0] frame_data;
  logic       write_ok;
  logic       read_ok;

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk (clk), .rst (rst), .d (sclk), .q (sclk_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk (clk), .rst (rst), .d (copi), .q (copi_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk (clk), .rst (rst), .d (ncs), .q (ncs_s)
  );

  // After reset the synchronizers still hold idle levels; if ncs is actually
  // low (reset in mid-frame) the chain flushing out would look like a falling
  // edge. Edges are masked until the chains and the edge registers carry real
  // pin values, so an interrupted frame's tail is ignored until a new fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q    <= 1'b0;
      ncs_q     <= 1'b1;
      flush_cnt <= '0;
    end else begin
      sclk_q <= sclk_s;
      ncs_q  <= ncs_s;
      if (flush_cnt != FL_MAX) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

  assign edges_ok  = (flush_cnt == FL_MAX);
  assign sclk_rise = edges_ok &  sclk_s & ~sclk_q;
  assign ncs_fall  = edges_ok & ~ncs_s  &  ncs_q;
  assign ncs_rise  = edges_ok &  ncs_s  & ~ncs_q;

  assign frame_rw   = shreg[FRAME_BITS-1];
  assign frame_addr = shreg[FRAME_BITS-2 -: 7];
  assign frame_data = shreg[7:0];
  assign write_ok   = (bit_cnt == CNT_FULL) && frame_rw && (frame_addr <= ADDR_PWM_DUTY);
  assign read_ok    = (bit_cnt == CNT_FULL) && !frame_rw;

  // Frame verdict is decided on the SHIFT->COMMIT transition so that the
  // strobes are high while COMMIT is active; the register write lands at the
  // end of COMMIT. Counter and shift register are frozen during COMMIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      bit_cnt         <= '0;
      shreg           <= '0;
      fall_pend       <= 1'b0;
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
      wr_strobe       <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (ncs_fall || fall_pend) begin
            state     <= SHIFT;
            bit_cnt   <= '0;
            shreg     <= '0;
            fall_pend <= 1'b0;
          end
        end
        SHIFT: begin
          if (ncs_rise) begin
            state     <= COMMIT;
            wr_strobe <= write_ok;
            frame_err <= !write_ok && !read_ok;
          end else if (sclk_rise) begin
            shreg <= {shreg[FRAME_BITS-2:0], copi_s};
            if (bit_cnt != CNT_MAX) begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        COMMIT: begin
          state <= IDLE;
          // A new frame starting right away is remembered for IDLE.
          if (ncs_fall) begin
            fall_pend <= 1'b1;
          end
          if (write_ok) begin
            case (frame_addr)
              ADDR_EN_OUT_7_0:  en_reg_out_7_0  <= frame_data;
              ADDR_EN_OUT_15_8: en_reg_out_15_8 <= frame_data;
              ADDR_EN_PWM_7_0:  en_reg_pwm_7_0  <= frame_data;
              ADDR_EN_PWM_15_8: en_reg_pwm_15_8 <= frame_data;
              ADDR_PWM_DUTY:    pwm_duty_cycle  <= frame_data;
              default: ;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cfg_regs.sv
// Self-checking bench for spi_cfg_regs: directed SPI frames at sclk = clk/8,
// a register/pulse model derived from the frame rules, and a per-cycle
// comparison of the register outputs while no frame is in flight.
module tb_spi_cfg_regs;

  logic clk = 1'b0;
  logic rst, sclk, copi, ncs;
  logic [7:0] out_lo, out_hi, pwm_lo, pwm_hi, duty;
  logic wr_strobe, frame_err;

  int checks = 0;
  int errors = 0;
  int wr_seen = 0;
  int err_seen = 0;
  int exp_wr = 0;
  int exp_err = 0;
  int base_wr;
  int base_err;
  logic quiet = 1'b0;
  logic [7:0] mregs [0:4];

  always #5 clk = ~clk;

  spi_cfg_regs #(.SYNC_STAGES(2), .FRAME_BITS(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .sclk            (sclk),
    .copi            (copi),
    .ncs             (ncs),
    .en_reg_out_7_0  (out_lo),
    .en_reg_out_15_8 (out_hi),
    .en_reg_pwm_7_0  (pwm_lo),
    .en_reg_pwm_15_8 (pwm_hi),
    .pwm_duty_cycle  (duty),
    .wr_strobe       (wr_strobe),
    .frame_err       (frame_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_reg(input int idx);
    case (idx)
      0: return out_lo;
      1: return out_hi;
      2: return pwm_lo;
      3: return pwm_hi;
      default: return duty;
    endcase
  endfunction

  // Per-cycle compare and pulse counting
  always begin
    @(posedge clk);
    #2;
    if (wr_strobe) wr_seen++;
    if (frame_err) err_seen++;
    if (quiet) begin
      for (int i = 0; i < 5; i++) check($sformatf("reg%0d", i), dut_reg(i), mregs[i]);
      check("idle_wr_strobe", wr_strobe, 0);
      check("idle_frame_err", frame_err, 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends the first n bits of d MSB first; bits past 16 are zero.
  task automatic shift_bits(input logic [15:0] d, input int n);
    logic [15:0] sh;
    sh = d;
    for (int k = 0; k < n; k++) begin
      copi = sh[15];
      sh = sh << 1;
      cycles(4);
      sclk = 1'b1;
      cycles(4);
      sclk = 1'b0;
    end
  endtask

  // Frame rules: a full-length write to address 0..4 commits, a full-length
  // read is ignored, anything else is an error.
  task automatic model_frame(input logic [15:0] d, input int n);
    if (n == 16 && d[15] && d[14:8] <= 7'h04) begin
      mregs[int'(d[14:8])] = d[7:0];
      exp_wr++;
    end else if (n == 16 && !d[15]) begin
      exp_wr = exp_wr;
    end else begin
      exp_err++;
    end
  endtask

  task automatic send_frame(input logic [15:0] d, input int n);
    quiet = 1'b0;
    ncs = 1'b0;
    cycles(4);
    shift_bits(d, n);
    cycles(4);
    ncs = 1'b1;
    cycles(12);
    model_frame(d, n);
    check("wr_strobe_count", wr_seen, exp_wr);
    check("frame_err_count", err_seen, exp_err);
    quiet = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 5; i++) mregs[i] = 8'h00;
    rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    cycles(4);
    rst = 1'b0;
    cycles(1);
    check("rst_out_lo", out_lo, 8'h00);
    check("rst_out_hi", out_hi, 8'h00);
    check("rst_pwm_lo", pwm_lo, 8'h00);
    check("rst_pwm_hi", pwm_hi, 8'h00);
    check("rst_duty", duty, 8'h00);
    check("rst_wr_strobe", wr_strobe, 0);
    check("rst_frame_err", frame_err, 0);
    quiet = 1'b1;
    cycles(4);

    // Single write to address 0
    send_frame(16'h8055, 16);
    check("lit_out_lo_55", out_lo, 8'h55);
    check("lit_pwm_hi_0", pwm_hi, 8'h00);
    check("lit_wr_1", wr_seen, 1);

    // Two duty writes
    base_wr = wr_seen;
    send_frame(16'h8480, 16);
    check("lit_duty_80", duty, 8'h80);
    send_frame(16'h84FF, 16);
    check("lit_duty_ff", duty, 8'hFF);
    check("lit_wr_delta_2", wr_seen - base_wr, 2);

    // Out-of-range address
    base_wr = wr_seen; base_err = err_seen;
    send_frame(16'h8512, 16);
    check("lit_badaddr_err", err_seen - base_err, 1);
    check("lit_badaddr_wr", wr_seen - base_wr, 0);

    // Short and long frames
    base_err = err_seen;
    send_frame(16'h81AA, 15);
    send_frame(16'h81AA, 17);
    check("lit_len_err_2", err_seen - base_err, 2);
    check("lit_out_hi_0", out_hi, 8'h00);

    // Read frame is a no-op
    base_wr = wr_seen; base_err = err_seen;
    send_frame(16'h0200, 16);
    check("lit_read_wr", wr_seen - base_wr, 0);
    check("lit_read_err", err_seen - base_err, 0);
    check("lit_read_pwm_lo", pwm_lo, 8'h00);

    // Reset in mid-frame, then the tail of that frame, then a full frame
    quiet = 1'b0;
    base_wr = wr_seen; base_err = err_seen;
    ncs = 1'b0;
    cycles(4);
    shift_bits(16'h83CC, 8);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) mregs[i] = 8'h00;
    cycles(1);
    check("mid_rst_out_lo", out_lo, 8'h00);
    check("mid_rst_duty", duty, 8'h00);
    check("mid_rst_pwm_hi", pwm_hi, 8'h00);
    quiet = 1'b1;
    shift_bits(16'hCC00, 8);
    cycles(4);
    ncs = 1'b1;
    cycles(12);
    check("lit_lost_wr", wr_seen - base_wr, 0);
    check("lit_lost_err", err_seen - base_err, 0);
    check("lit_lost_pwm_hi", pwm_hi, 8'h00);
    send_frame(16'h83CC, 16);
    check("lit_pwm_hi_cc", pwm_hi, 8'hCC);
    check("lit_final_wr", wr_seen - base_wr, 1);

    cycles(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
